// File: rtl/dfx_seq_pkg.sv
// Shared definitions for the DFX sequencer slot table: status encodings,
// default field widths and the default slot count.
package dfx_seq_pkg;

  localparam int DEF_INDEX_WIDTH    = 2;
  localparam int DEF_ADDR_WIDTH     = 32;
  localparam int DEF_SIZE_WIDTH     = 26;
  localparam int DEF_STATUS_WIDTH   = 2;
  localparam int DEF_PROFILE_WIDTH  = 32;
  localparam int DEF_NUM_SLOTS      = 2 ** DEF_INDEX_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BUSY  = 2'b01,
    ST_DONE  = 2'b10,
    ST_ERROR = 2'b11
  } status_e;

  // Final status of a slot when the sequencer closes it; error dominates.
  function automatic status_e close_status(input logic err);
    if (err) begin
      return ST_ERROR;
    end else begin
      return ST_DONE;
    end
  endfunction

endpackage

// File: rtl/bank1_slot_table_sat_counter.sv
// Saturating up-counter with a synchronous parallel load.
// Load has priority over increment; the count sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  // Next count: load, else saturating increment, else hold.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/bank1_slot_table.sv
// Slot table: per-slot descriptor rows written by the host decoder strobes,
// registered host reads and sequencer loads, slot status tracking and
// cycle profiling of the active slot.
module bank1_slot_table
  import dfx_seq_pkg::*;
#(
  parameter int INDEX_WIDTH    = DEF_INDEX_WIDTH,
  parameter int SRC_ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DST_ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int SRC_SIZE_WIDTH = DEF_SIZE_WIDTH,
  parameter int DST_SIZE_WIDTH = DEF_SIZE_WIDTH,
  parameter int STATUS_WIDTH   = DEF_STATUS_WIDTH,
  parameter int PROFILE_WIDTH  = DEF_PROFILE_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [INDEX_WIDTH-1:0]    inp_index,
  input  logic [SRC_ADDR_WIDTH-1:0] inp_src_addr,
  input  logic [SRC_SIZE_WIDTH-1:0] inp_src_size,
  input  logic [DST_ADDR_WIDTH-1:0] inp_des_addr,
  input  logic [DST_SIZE_WIDTH-1:0] inp_des_size,
  input  logic [STATUS_WIDTH-1:0]   inp_status,
  input  logic [PROFILE_WIDTH-1:0]  inp_profile,
  input  logic                      set_src_addr,
  input  logic                      set_src_size,
  input  logic                      set_des_addr,
  input  logic                      set_des_size,
  input  logic                      set_status,
  input  logic                      set_profile,
  input  logic                      rd_req,
  input  logic [INDEX_WIDTH-1:0]    rd_index,
  output logic                      rd_valid,
  output logic [SRC_ADDR_WIDTH-1:0] rd_src_addr,
  output logic [SRC_SIZE_WIDTH-1:0] rd_src_size,
  output logic [DST_ADDR_WIDTH-1:0] rd_des_addr,
  output logic [DST_SIZE_WIDTH-1:0] rd_des_size,
  output logic [STATUS_WIDTH-1:0]   rd_status,
  output logic [PROFILE_WIDTH-1:0]  rd_profile,
  input  logic                      seq_load,
  input  logic [INDEX_WIDTH-1:0]    seq_index,
  output logic                      seq_load_valid,
  output logic [SRC_ADDR_WIDTH-1:0] seq_src_addr,
  output logic [SRC_SIZE_WIDTH-1:0] seq_src_size,
  output logic [DST_ADDR_WIDTH-1:0] seq_des_addr,
  output logic [DST_SIZE_WIDTH-1:0] seq_des_size,
  input  logic                      seq_start,
  input  logic                      seq_done,
  input  logic                      seq_error,
  output logic                      seq_busy_err
);

  localparam int NUM_SLOTS = 2 ** INDEX_WIDTH;

  // Row storage
  logic [SRC_ADDR_WIDTH-1:0] src_addr_q [NUM_SLOTS];
  logic [SRC_ADDR_WIDTH-1:0] src_addr_d [NUM_SLOTS];
  logic [SRC_SIZE_WIDTH-1:0] src_size_q [NUM_SLOTS];
  logic [SRC_SIZE_WIDTH-1:0] src_size_d [NUM_SLOTS];
  logic [DST_ADDR_WIDTH-1:0] des_addr_q [NUM_SLOTS];
  logic [DST_ADDR_WIDTH-1:0] des_addr_d [NUM_SLOTS];
  logic [DST_SIZE_WIDTH-1:0] des_size_q [NUM_SLOTS];
  logic [DST_SIZE_WIDTH-1:0] des_size_d [NUM_SLOTS];
  logic [STATUS_WIDTH-1:0]   status_q   [NUM_SLOTS];
  logic [STATUS_WIDTH-1:0]   status_d   [NUM_SLOTS];
  logic [PROFILE_WIDTH-1:0]  profile_s  [NUM_SLOTS];
  logic [PROFILE_WIDTH-1:0]  prof_val_s [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]      prof_load_s;
  logic [NUM_SLOTS-1:0]      prof_inc_s;

  // Active-slot tracker
  logic                   active_q, active_d;
  logic [INDEX_WIDTH-1:0] active_idx_q, active_idx_d;
  logic                   busy_err_q, busy_err_d;
  logic                   close_s;
  logic                   start_ok_s;

  // Output registers
  logic                      rd_valid_q, rd_valid_d;
  logic [SRC_ADDR_WIDTH-1:0] rd_src_addr_q, rd_src_addr_d;
  logic [SRC_SIZE_WIDTH-1:0] rd_src_size_q, rd_src_size_d;
  logic [DST_ADDR_WIDTH-1:0] rd_des_addr_q, rd_des_addr_d;
  logic [DST_SIZE_WIDTH-1:0] rd_des_size_q, rd_des_size_d;
  logic [STATUS_WIDTH-1:0]   rd_status_q, rd_status_d;
  logic [PROFILE_WIDTH-1:0]  rd_profile_q, rd_profile_d;
  logic                      ld_valid_q, ld_valid_d;
  logic [SRC_ADDR_WIDTH-1:0] ld_src_addr_q, ld_src_addr_d;
  logic [SRC_SIZE_WIDTH-1:0] ld_src_size_q, ld_src_size_d;
  logic [DST_ADDR_WIDTH-1:0] ld_des_addr_q, ld_des_addr_d;
  logic [DST_SIZE_WIDTH-1:0] ld_des_size_q, ld_des_size_d;

  // Tracker: a close in the same cycle frees the table for a new start.
  always_comb begin
    close_s      = active_q && (seq_done || seq_error);
    start_ok_s   = seq_start && (!active_q || close_s);
    busy_err_d   = seq_start && active_q && !close_s;
    active_d     = active_q;
    active_idx_d = active_idx_q;
    if (start_ok_s) begin
      active_d     = 1'b1;
      active_idx_d = seq_index;
    end else if (close_s) begin
      active_d     = 1'b0;
      active_idx_d = active_idx_q;
    end else begin
      active_d     = active_q;
      active_idx_d = active_idx_q;
    end
  end

  // Row updates: host strobes, then sequencer status transitions on top.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      src_addr_d[i] = src_addr_q[i];
      src_size_d[i] = src_size_q[i];
      des_addr_d[i] = des_addr_q[i];
      des_size_d[i] = des_size_q[i];
      status_d[i]   = status_q[i];
      if (inp_index == INDEX_WIDTH'(i)) begin
        if (set_src_addr) src_addr_d[i] = inp_src_addr; else src_addr_d[i] = src_addr_q[i];
        if (set_src_size) src_size_d[i] = inp_src_size; else src_size_d[i] = src_size_q[i];
        if (set_des_addr) des_addr_d[i] = inp_des_addr; else des_addr_d[i] = des_addr_q[i];
        if (set_des_size) des_size_d[i] = inp_des_size; else des_size_d[i] = des_size_q[i];
        if (set_status)   status_d[i]   = inp_status;   else status_d[i]   = status_q[i];
      end else begin
        status_d[i] = status_q[i];
      end
      // Close before start so a same-row close+start ends up BUSY.
      if (close_s && (active_idx_q == INDEX_WIDTH'(i))) begin
        status_d[i] = STATUS_WIDTH'(close_status(seq_error));
      end else begin
        status_d[i] = status_d[i];
      end
      if (start_ok_s && (seq_index == INDEX_WIDTH'(i))) begin
        status_d[i] = STATUS_WIDTH'(ST_BUSY);
      end else begin
        status_d[i] = status_d[i];
      end
    end
  end

  // Profile control: host load beats the start-time clear; counting follows the active slot.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      prof_load_s[i] = 1'b0;
      prof_val_s[i]  = {PROFILE_WIDTH{1'b0}};
      if (set_profile && (inp_index == INDEX_WIDTH'(i))) begin
        prof_load_s[i] = 1'b1;
        prof_val_s[i]  = inp_profile;
      end else if (start_ok_s && (seq_index == INDEX_WIDTH'(i))) begin
        prof_load_s[i] = 1'b1;
        prof_val_s[i]  = {PROFILE_WIDTH{1'b0}};
      end else begin
        prof_load_s[i] = 1'b0;
        prof_val_s[i]  = {PROFILE_WIDTH{1'b0}};
      end
      prof_inc_s[i] = active_q && (active_idx_q == INDEX_WIDTH'(i));
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_prof
    sat_counter #(.WIDTH(PROFILE_WIDTH)) u_prof (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (prof_load_s[g]),
      .load_val (prof_val_s[g]),
      .inc      (prof_inc_s[g]),
      .count    (profile_s[g])
    );
  end

  // Read and load muxes: snapshot the pre-edge row, hold data when idle.
  always_comb begin
    rd_valid_d    = rd_req;
    rd_src_addr_d = rd_src_addr_q;
    rd_src_size_d = rd_src_size_q;
    rd_des_addr_d = rd_des_addr_q;
    rd_des_size_d = rd_des_size_q;
    rd_status_d   = rd_status_q;
    rd_profile_d  = rd_profile_q;
    if (rd_req) begin
      rd_src_addr_d = src_addr_q[rd_index];
      rd_src_size_d = src_size_q[rd_index];
      rd_des_addr_d = des_addr_q[rd_index];
      rd_des_size_d = des_size_q[rd_index];
      rd_status_d   = status_q[rd_index];
      rd_profile_d  = profile_s[rd_index];
    end else begin
      rd_status_d   = rd_status_q;
    end
    ld_valid_d    = seq_load;
    ld_src_addr_d = ld_src_addr_q;
    ld_src_size_d = ld_src_size_q;
    ld_des_addr_d = ld_des_addr_q;
    ld_des_size_d = ld_des_size_q;
    if (seq_load) begin
      ld_src_addr_d = src_addr_q[seq_index];
      ld_src_size_d = src_size_q[seq_index];
      ld_des_addr_d = des_addr_q[seq_index];
      ld_des_size_d = des_size_q[seq_index];
    end else begin
      ld_src_addr_d = ld_src_addr_q;
    end
  end

  // Row storage and tracker registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        src_addr_q[i] <= {SRC_ADDR_WIDTH{1'b0}};
        src_size_q[i] <= {SRC_SIZE_WIDTH{1'b0}};
        des_addr_q[i] <= {DST_ADDR_WIDTH{1'b0}};
        des_size_q[i] <= {DST_SIZE_WIDTH{1'b0}};
        status_q[i]   <= {STATUS_WIDTH{1'b0}};
      end
      active_q     <= 1'b0;
      active_idx_q <= {INDEX_WIDTH{1'b0}};
      busy_err_q   <= 1'b0;
    end else begin
      src_addr_q   <= src_addr_d;
      src_size_q   <= src_size_d;
      des_addr_q   <= des_addr_d;
      des_size_q   <= des_size_d;
      status_q     <= status_d;
      active_q     <= active_d;
      active_idx_q <= active_idx_d;
      busy_err_q   <= busy_err_d;
    end
  end

  // Read and load output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q    <= 1'b0;
      rd_src_addr_q <= {SRC_ADDR_WIDTH{1'b0}};
      rd_src_size_q <= {SRC_SIZE_WIDTH{1'b0}};
      rd_des_addr_q <= {DST_ADDR_WIDTH{1'b0}};
      rd_des_size_q <= {DST_SIZE_WIDTH{1'b0}};
      rd_status_q   <= {STATUS_WIDTH{1'b0}};
      rd_profile_q  <= {PROFILE_WIDTH{1'b0}};
      ld_valid_q    <= 1'b0;
      ld_src_addr_q <= {SRC_ADDR_WIDTH{1'b0}};
      ld_src_size_q <= {SRC_SIZE_WIDTH{1'b0}};
      ld_des_addr_q <= {DST_ADDR_WIDTH{1'b0}};
      ld_des_size_q <= {DST_SIZE_WIDTH{1'b0}};
    end else begin
      rd_valid_q    <= rd_valid_d;
      rd_src_addr_q <= rd_src_addr_d;
      rd_src_size_q <= rd_src_size_d;
      rd_des_addr_q <= rd_des_addr_d;
      rd_des_size_q <= rd_des_size_d;
      rd_status_q   <= rd_status_d;
      rd_profile_q  <= rd_profile_d;
      ld_valid_q    <= ld_valid_d;
      ld_src_addr_q <= ld_src_addr_d;
      ld_src_size_q <= ld_src_size_d;
      ld_des_addr_q <= ld_des_addr_d;
      ld_des_size_q <= ld_des_size_d;
    end
  end

  assign rd_valid       = rd_valid_q;
  assign rd_src_addr    = rd_src_addr_q;
  assign rd_src_size    = rd_src_size_q;
  assign rd_des_addr    = rd_des_addr_q;
  assign rd_des_size    = rd_des_size_q;
  assign rd_status      = rd_status_q;
  assign rd_profile     = rd_profile_q;
  assign seq_load_valid = ld_valid_q;
  assign seq_src_addr   = ld_src_addr_q;
  assign seq_src_size   = ld_src_size_q;
  assign seq_des_addr   = ld_des_addr_q;
  assign seq_des_size   = ld_des_size_q;
  assign seq_busy_err   = busy_err_q;

endmodule
